// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline sequencer for the 5-stage core.
//
// Merges the per-stage stall requests into the 6-bit stall vector used by the
// PC and the inter-stage registers, and owns exception/ERET redirection. It
// raises a one-cycle flush with the redirect PC. A redirect is deferred while
// a data-bus transaction is in flight. It also keeps a saturating count of
// the cycles in which the PC was stalled.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   stallreq_if/id/ex/mem  per-stage stall requests (mem = highest priority)
//   excepttype        exception code from MEM stage, 0 = none
//   cp0_epc           current EPC from CP0
//   stall[5:0]        bit0 PC .. bit5 WB, 1 = stop (forced 0 during flush)
//   flush             clear all inter-stage registers this cycle
//   new_pc            redirect target, meaningful only when flush=1
//   stall_cnt         cycles with stall[0]=1, saturating at all-ones
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
  parameter int          RECOVER_CYCLES = 2,
  parameter int          CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic [31:0]      excepttype,
  input  logic [31:0]      cp0_epc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [31:0] CODE_ERET = 32'h0000_000e;

  typedef enum logic [1:0] {
    S_RUN,
    S_PEND,
    S_RECOVER
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         rcnt_q, rcnt_d;
  logic [31:0]        code_q, code_d;
  logic [31:0]        epc_q, epc_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               exc;

  // Highest-priority request wins; each stage stalls itself and everything
  // upstream of it.
  function automatic logic [5:0] stall_enc(input logic r_if, input logic r_id,
                                           input logic r_ex, input logic r_mem);
    if (r_mem)      return 6'b011111;
    else if (r_ex)  return 6'b001111;
    else if (r_id)  return 6'b000111;
    else if (r_if)  return 6'b000011;
    else            return 6'b000000;
  endfunction

  function automatic logic [31:0] redirect_pc(input logic [31:0] code,
                                              input logic [31:0] epc);
    return (code == CODE_ERET) ? epc : EXC_VECTOR;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    code_d  = code_q;
    epc_d   = epc_q;
    flush   = 1'b0;
    new_pc  = 32'h0;
    stall   = stall_enc(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
    exc     = (excepttype != 32'h0) && (state_q == S_RUN);

    unique case (state_q)
      S_RUN: begin
        if (exc) begin
          if (!stallreq_mem) begin
            flush   = 1'b1;
            new_pc  = redirect_pc(excepttype, cp0_epc);
            state_d = S_RECOVER;
            rcnt_d  = 4'(RECOVER_CYCLES);
          end else begin
            // Bus busy: capture the exception now, since EPC may move on
            // before the transaction finishes.
            code_d  = excepttype;
            epc_d   = cp0_epc;
            state_d = S_PEND;
          end
        end
      end
      S_PEND: begin
        if (!stallreq_mem) begin
          flush   = 1'b1;
          new_pc  = redirect_pc(code_q, epc_q);
          state_d = S_RECOVER;
          rcnt_d  = 4'(RECOVER_CYCLES);
        end
      end
      S_RECOVER: begin
        rcnt_d = rcnt_q - 4'd1;
        if (rcnt_q <= 4'd1) begin
          state_d = S_RUN;
          rcnt_d  = 4'd0;
        end
      end
      default: state_d = S_RUN;
    endcase

    if (flush) stall = 6'b000000;

    if (rst) begin
      stall   = 6'b000000;
      flush   = 1'b0;
      new_pc  = 32'h0;
      state_d = S_RUN;
      rcnt_d  = 4'd0;
      code_d  = 32'h0;
      epc_d   = 32'h0;
    end

    stall_cnt_d = stall[0] ? sat_inc(stall_cnt_q) : stall_cnt_q;
    if (rst) stall_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    rcnt_q      <= rcnt_d;
    code_q      <= code_d;
    epc_q       <= epc_d;
    stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios followed by random traffic, all
// checked against a cycle-indexed behavioural model. A second instance with a
// 4-bit counter exercises saturation.
module tb_pipe_ctrl;

  localparam int RC = 2;

  logic        clk;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype, cp0_epc;
  logic [5:0]  stall, stall4;
  logic        flush, flush4;
  logic [31:0] new_pc, new_pc4;
  logic [31:0] stall_cnt;
  logic [3:0]  stall_cnt4;

  int tests = 0;
  int fails = 0;

  pipe_ctrl #(.EXC_VECTOR(32'h20), .RECOVER_CYCLES(RC), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excepttype(excepttype), .cp0_epc(cp0_epc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .stall_cnt(stall_cnt)
  );

  pipe_ctrl #(.EXC_VECTOR(32'h20), .RECOVER_CYCLES(RC), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excepttype(excepttype), .cp0_epc(cp0_epc),
    .stall(stall4), .flush(flush4), .new_pc(new_pc4), .stall_cnt(stall_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending exception slot, cycle of the last flush, counters.
  int          m_cyc = 0;
  int          m_last_flush = -1000;
  bit          m_pend = 0;
  logic [31:0] m_code = '0, m_epc = '0;
  logic [31:0] m_cnt = '0;
  logic [3:0]  m_cnt4 = '0;

  // Values observed in the most recent step (sampled mid-cycle).
  logic [5:0]  o_stall;
  logic        o_flush;
  logic [31:0] o_pc, o_cnt;
  logic [3:0]  o_cnt4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic i_if, input logic i_id,
                      input logic i_ex, input logic i_mem,
                      input logic [31:0] code, input logic [31:0] epc);
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    bit          latch;
    bit          ignore;
    @(negedge clk);
    rst = r; stallreq_if = i_if; stallreq_id = i_id;
    stallreq_ex = i_ex; stallreq_mem = i_mem;
    excepttype = code; cp0_epc = epc;
    #1;
    e_flush = 1'b0; e_pc = 32'h0; latch = 0;
    e_stall = i_mem ? 6'h1f : i_ex ? 6'h0f : i_id ? 6'h07 : i_if ? 6'h03 : 6'h00;
    ignore  = (m_cyc - m_last_flush) <= RC;
    if (r) begin
      e_stall = 6'h00;
    end else if (m_pend) begin
      if (!i_mem) begin
        e_flush = 1'b1;
        e_pc = (m_code == 32'he) ? m_epc : 32'h20;
      end
    end else if (code != 0 && !ignore) begin
      if (!i_mem) begin
        e_flush = 1'b1;
        e_pc = (code == 32'he) ? epc : 32'h20;
      end else begin
        latch = 1;
      end
    end
    if (e_flush) e_stall = 6'h00;

    o_stall = stall; o_flush = flush; o_pc = new_pc;
    o_cnt = stall_cnt; o_cnt4 = stall_cnt4;
    check("stall", {26'h0, stall}, {26'h0, e_stall});
    check("flush", {31'h0, flush}, {31'h0, e_flush});
    check("stall_cnt", stall_cnt, m_cnt);
    check("stall_cnt4", {28'h0, stall_cnt4}, {28'h0, m_cnt4});
    check("stall4", {26'h0, stall4}, {26'h0, e_stall});
    check("flush4", {31'h0, flush4}, {31'h0, e_flush});
    if (e_flush) begin
      check("new_pc", new_pc, e_pc);
      check("new_pc4", new_pc4, e_pc);
    end

    @(posedge clk);
    if (r) begin
      m_pend = 0; m_last_flush = -1000; m_cnt = '0; m_cnt4 = '0;
      m_code = '0; m_epc = '0;
    end else begin
      if (e_flush) begin
        m_last_flush = m_cyc; m_pend = 0;
      end else if (latch) begin
        m_pend = 1; m_code = code; m_epc = epc;
      end
      if (e_stall[0]) begin
        if (m_cnt != 32'hffff_ffff) m_cnt = m_cnt + 1;
        if (m_cnt4 != 4'hf) m_cnt4 = m_cnt4 + 1;
      end
    end
    m_cyc++;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] codes [4];
    codes[0] = 32'h8; codes[1] = 32'he; codes[2] = 32'hc; codes[3] = 32'h4;
    rst = 1; stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    excepttype = 0; cp0_epc = 0;

    // Reset and request priority
    step(1, 0, 0, 0, 0, 32'h0, 32'h0);
    check("rst_stall", {26'h0, o_stall}, 32'h0);
    check("rst_flush", {31'h0, o_flush}, 32'h0);
    check("rst_new_pc", o_pc, 32'h0);
    idle();
    check("idle_stall", {26'h0, o_stall}, 32'h0);
    check("idle_cnt", o_cnt, 32'h0);
    step(0, 0, 1, 1, 0, 32'h0, 32'h0);
    check("id_ex_stall", {26'h0, o_stall}, 32'h0f);
    step(0, 0, 1, 0, 0, 32'h0, 32'h0);
    check("id_stall", {26'h0, o_stall}, 32'h07);
    idle();
    check("none_stall", {26'h0, o_stall}, 32'h0);

    // Syscall with recovery window
    step(0, 1, 0, 1, 0, 32'h8, 32'h0);
    check("sys_flush", {31'h0, o_flush}, 32'h1);
    check("sys_pc", o_pc, 32'h20);
    check("sys_stall", {26'h0, o_stall}, 32'h0);
    step(0, 0, 0, 0, 0, 32'h8, 32'h0);
    check("sys_rec1", {31'h0, o_flush}, 32'h0);
    step(0, 0, 0, 0, 0, 32'h8, 32'h0);
    check("sys_rec2", {31'h0, o_flush}, 32'h0);
    idle();

    // ERET
    step(0, 0, 0, 0, 0, 32'he, 32'h0040_0104);
    check("eret_flush", {31'h0, o_flush}, 32'h1);
    check("eret_pc", o_pc, 32'h0040_0104);
    idle(); idle();

    // Deferred exception behind a data-bus transaction
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 0, 0, 1, codes[k == 0 ? 2 : 1], 32'h0000_1000);
      check("pend_flush0", {31'h0, o_flush}, 32'h0);
      check("pend_stall0", {26'h0, o_stall}, 32'h1f);
      for (int j = 0; j < 2; j++) begin
        step(0, 0, 0, 0, 1, 32'h0, 32'h0000_2000 + j);
        check("pend_flush", {31'h0, o_flush}, 32'h0);
        check("pend_stall", {26'h0, o_stall}, 32'h1f);
      end
      step(0, 0, 0, 0, 0, 32'h0, 32'h0000_3000);
      check("pend_redirect", {31'h0, o_flush}, 32'h1);
      check("pend_pc", o_pc, (k == 0) ? 32'h20 : 32'h0000_1000);
      idle(); idle();
    end

    // Reset in the middle of a pending exception
    step(0, 0, 0, 0, 1, 32'hc, 32'h0);
    step(1, 0, 0, 0, 1, 32'h0, 32'h0);
    for (int j = 0; j < 3; j++) begin
      idle();
      check("rstpend_flush", {31'h0, o_flush}, 32'h0);
      check("rstpend_cnt", o_cnt, 32'h0);
    end

    // Stall counter and saturation
    step(1, 0, 0, 0, 0, 32'h0, 32'h0);
    for (int j = 0; j < 10; j++) step(0, 1, 0, 0, 0, 32'h0, 32'h0);
    idle();
    check("cnt10", o_cnt, 32'd10);
    for (int j = 0; j < 10; j++) step(0, 1, 0, 0, 0, 32'h0, 32'h0);
    idle();
    check("cnt20", o_cnt, 32'd20);
    check("cnt4_sat", {28'h0, o_cnt4}, 32'hf);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] c;
      c = 32'h0;
      if ($urandom_range(4) == 0) begin
        c = codes[$urandom_range(3)];
        if ($urandom_range(5) == 0) c = $urandom | 32'h1;
      end
      step($urandom_range(99) == 0, $urandom_range(2) == 0, $urandom_range(3) == 0,
           $urandom_range(4) == 0, $urandom_range(2) == 0, c, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. Merges per-stage stall requests into the 6-bit stall vector consumed by the PC and all inter-stage registers (if_id, id_ex, ex_mem, mem_wb). Also owns exception/ERET redirection: it drives the one-cycle flush and the redirect PC. When a data-bus transaction is in flight, it defers the redirect until the transaction completes. Also exports a saturating stall-cycle counter for performance monitoring.

Parameters:
EXC_VECTOR, 32'h00000020, redirect PC for every exception except ERET
RECOVER_CYCLES, 2, cycles after a flush during which excepttype is ignored (1..15)
CNT_W, 32, width of stall_cnt

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stallreq_if  in  1  instruction-bus wait
stallreq_id  in  1  load-use hazard
stallreq_ex  in  1  multi-cycle EX op (div, madd)
stallreq_mem  in  1  data-bus transaction in flight
excepttype  in  32  exception code from MEM stage, 0 = none
cp0_epc  in  32  current EPC from CP0
stall  out  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = stop
flush  out  1  clear all inter-stage registers this cycle
new_pc  out  32  redirect target, meaningful only when flush=1
stall_cnt  out  CNT_W  cycles with stall[0]=1, saturating

Behaviour:
- Clock, reset: reset rst, synchronous, active-high; clock clk. All state updates on posedge clk.
- On reset: state=RUN, recover counter=0, latched code/epc=0, stall_cnt=0.
- Combinational outputs during reset: stall=0, flush=0, new_pc=0.
- Stall encoding is combinational. The highest-priority request wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 0
- Whenever flush=1, stall is forced to 0.
- Exception pending: exc = (excepttype != 0) && state==RUN.
- States:
  - RUN:
    - exc && !stallreq_mem → flush=1 this cycle (combinational, zero latency); new_pc selected from the live excepttype/cp0_epc; next state RECOVER.
    - exc && stallreq_mem → flush=0; stall=6'b011111; latch excepttype and cp0_epc; next state PEND.
  - PEND:
    - Hold while stallreq_mem=1; stall follows request priority.
    - First cycle stallreq_mem=0 → flush=1; new_pc derived from the latched values; next state RECOVER.
    - Live excepttype is ignored in PEND.
  - RECOVER:
    - Load counter with RECOVER_CYCLES on entry.
    - Decrement each cycle; return to RUN when the counter reaches 1.
    - excepttype is ignored; stall requests are honoured normally.
- new_pc select:
  - code == 32'h0000000e (ERET) → epc (live or latched as above).
  - Any other nonzero code → EXC_VECTOR.
- Simultaneous events:
  - A flush overrides every stall request in the same cycle.
  - rst overrides everything, including an in-progress PEND; the latched exception is discarded.
- stall_cnt increments when stall[0]=1 and rst=0; holds at all-ones.

Test Plan:
- Request priority: rst then idle → stall=0, stall_cnt=0. Assert stallreq_id=1 and stallreq_ex=1 together → stall=6'b001111. Drop ex → 6'b000111. Drop all → 0.
- Syscall: excepttype=32'h8 for one cycle, stallreq_mem=0 → same-cycle flush=1, new_pc=32'h20, stall=0. Next 2 cycles: excepttype=32'h8 → flush=0.
- ERET: cp0_epc=32'h00400104, excepttype=32'he → flush=1, new_pc=32'h00400104.
- Deferred exception:
  - Inputs: stallreq_mem=1 for 3 cycles with excepttype=32'hc on the first; cp0_epc changes after that first cycle.
  - While stallreq_mem=1: flush=0, stall=6'b011111.
  - Cycle after stallreq_mem drops: flush=1, new_pc=32'h20.
  - Same check with excepttype=32'he: new_pc = the epc latched on the first cycle.
- Reset mid-PEND: enter PEND, assert rst one cycle, release with stallreq_mem=0 and excepttype=0 → no flush ever; stall_cnt=0.
- Counter: hold stallreq_if=1 for 10 cycles → stall_cnt=10. With CNT_W=4 and 20 cycles → stall_cnt=4'hf.
